// File: rtl/dma_bus_arbiter.sv
// Shares the 16-bit memory bus between the 8227 CPU core and a DMA requester.
// Optional ROM write protection for DMA is enabled by defining ARB_WRITE_PROTECT_EN.
module dma_bus_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int CPU_SLOTS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpuAddr,
  input  logic        cpuRnw,
  input  logic [7:0]  cpuWdata,
  output logic [7:0]  cpuRdata,
  output logic        cpuRdy,
  input  logic        dmaReq,
  input  logic [15:0] dmaAddr,
  input  logic        dmaRnw,
  input  logic [7:0]  dmaWdata,
  output logic        dmaGnt,
  output logic [7:0]  dmaRdata,
  output logic        dmaErr,
  output logic [15:0] memAddr,
  output logic        memRnw,
  output logic [7:0]  memWdata,
  input  logic [7:0]  memRdata
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(CPU_SLOTS + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST);
  localparam logic [SW-1:0] SLOT_FULL  = SW'(CPU_SLOTS);

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    STALL   = 2'd1,
    DMA_OWN = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [SW-1:0]   slot_q,  slot_d;
  logic            wp_block;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CPU_OWN;
      burst_q <= '0;
      slot_q  <= SLOT_FULL;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      slot_q  <= slot_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    slot_d  = slot_q;
    unique case (state_q)
      CPU_OWN: begin
        if (slot_q != SLOT_FULL) slot_d = slot_q + 1'b1;
        if (dmaReq && (slot_q == SLOT_FULL)) state_d = STALL;
      end
      STALL: begin
        // The CPU ignores ready during writes, so the grant waits for a read cycle.
        if (!dmaReq) begin
          state_d = CPU_OWN;
        end else if (cpuRnw) begin
          state_d = DMA_OWN;
          burst_d = '0;
        end
      end
      DMA_OWN: begin
        if (dmaReq) begin
          burst_d = burst_q + 1'b1;
          if (burst_d == BURST_LAST) state_d = RELEASE;
        end else begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        slot_d  = '0;
        state_d = CPU_OWN;
      end
      default: state_d = CPU_OWN;
    endcase
  end

  // Handshake outputs come straight from the state register: no combinational path from dmaReq.
  assign cpuRdy = (state_q == CPU_OWN);
  assign dmaGnt = (state_q == DMA_OWN);

`ifdef ARB_WRITE_PROTECT_EN
  logic err_q;

  assign wp_block = dmaGnt && !dmaRnw && dmaAddr[15];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= wp_block && dmaReq;
  end

  assign dmaErr = err_q;
`else
  assign wp_block = 1'b0;
  assign dmaErr   = 1'b0;
`endif

  always_comb begin
    memAddr  = cpuAddr;
    memRnw   = cpuRnw;
    memWdata = cpuWdata;
    cpuRdata = memRdata;
    dmaRdata = 8'h00;
    if (dmaGnt) begin
      memAddr  = dmaAddr;
      memRnw   = dmaRnw | wp_block;
      memWdata = dmaWdata;
      cpuRdata = 8'h00;
      dmaRdata = memRdata;
    end
  end

endmodule
